td4_top: RTL and testbench

//  FPGA top of the TD4 4-bit CPU: prescaler, fixed 16x8 program ROM, CPU core (A, B, OUT, PC, carry).

---
 rtl/td4_top.sv | 86 ++++++++
 tb/tb_td4_top.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/td4_top.sv
// TD4 4-bit CPU top: prescaler, fixed 16x8 program ROM, core (A, B, OUT, PC, C); one step per 2*RATIO clocks.
// pin_led follows the OUT register directly with no added latency; no backpressure, pin_switch is sampled on the step edge.
module td4_top #(
    parameter int unsigned RATIO = 50_000_000
) (
    input  logic       pin_clock,
    input  logic       pin_reset,
    input  logic [3:0] pin_switch,
    output logic [3:0] pin_led
);
    logic [31:0] count;
    logic        slow_clock;
    logic        step;
    logic [3:0]  a, b, out_port, pc;
    logic        c;
    logic [7:0]  instr;
    logic [3:0]  opcode, im;
    logic [3:0]  alu_src;
    logic [4:0]  alu_sum;
    logic        alu_carry;

    // Step strobe is the clock edge on which slow_clock rises.
    assign step = (count == 32'(RATIO - 1)) && !slow_clock;

    always_comb begin
        instr = 8'h00;
        case (pc)
            4'd0:    instr = 8'h20;
            4'd1:    instr = 8'h40;
            4'd2:    instr = 8'h90;
            4'd3:    instr = 8'h51;
            4'd4:    instr = 8'hE2;
            4'd5:    instr = 8'hF0;
            default: instr = 8'h00;
        endcase
    end

    assign opcode = instr[7:4];
    assign im     = instr[3:0];

    // Only the two ADD opcodes can produce a carry; everything else clears C.
    assign alu_src   = (opcode == 4'b0101) ? b : a;
    assign alu_sum   = {1'b0, alu_src} + {1'b0, im};
    assign alu_carry = ((opcode == 4'b0000) || (opcode == 4'b0101)) ? alu_sum[4] : 1'b0;

    always_ff @(posedge pin_clock or posedge pin_reset) begin
        if (pin_reset) begin
            count      <= 32'd0;
            slow_clock <= 1'b0;
            a          <= 4'h0;
            b          <= 4'h0;
            out_port   <= 4'h0;
            pc         <= 4'h0;
            c          <= 1'b0;
        end else begin
            if (count == 32'(RATIO - 1)) begin
                count      <= 32'd0;
                slow_clock <= ~slow_clock;
            end else begin
                count <= count + 32'd1;
            end

            if (step) begin
                c  <= alu_carry;
                pc <= pc + 4'd1;
                case (opcode)
                    4'b0000: a        <= alu_sum[3:0];
                    4'b0101: b        <= alu_sum[3:0];
                    4'b0011: a        <= im;
                    4'b0111: b        <= im;
                    4'b0001: a        <= b;
                    4'b0100: b        <= a;
                    4'b0010: a        <= pin_switch;
                    4'b0110: b        <= pin_switch;
                    4'b1001: out_port <= b;
                    4'b1011: out_port <= im;
                    4'b1111: pc       <= im;
                    4'b1110: if (!c) pc <= im;
                    default: ;
                endcase
            end
        end
    end

    assign pin_led = out_port;
endmodule

// File: tb/tb_td4_top.sv
// Randomized scoreboard bench for td4_top (RATIO=2) against an instruction-level model of the TD4 program.
module tb_td4_top;
    logic       pin_clock = 1'b0;
    logic       pin_reset = 1'b0;
    logic [3:0] pin_switch = 4'd6;
    logic [3:0] pin_led;

    td4_top #(.RATIO(2)) dut (
        .pin_clock (pin_clock),
        .pin_reset (pin_reset),
        .pin_switch(pin_switch),
        .pin_led   (pin_led)
    );

    always #5 pin_clock = ~pin_clock;

    typedef struct packed {
        logic [3:0] led;
        logic       slow;
        logic [3:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Instruction-level model: program counter, registers, and a rise counter for step timing.
    int        m_a, m_b, m_out, m_pc, m_c, rises;
    logic [7:0] m_rom [16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0; rises = 0;
    endtask

    task automatic model_step();
        int op, im, s, nc, npc;
        op  = int'(m_rom[m_pc][7:4]);
        im  = int'(m_rom[m_pc][3:0]);
        nc  = 0;
        npc = (m_pc + 1) % 16;
        case (op)
            0:  begin s = m_a + im; m_a = s % 16; nc = (s >= 16) ? 1 : 0; end
            5:  begin s = m_b + im; m_b = s % 16; nc = (s >= 16) ? 1 : 0; end
            3:  m_a = im;
            7:  m_b = im;
            1:  m_a = m_b;
            4:  m_b = m_a;
            2:  m_a = int'(pin_switch);
            6:  m_b = int'(pin_switch);
            9:  m_out = m_b;
            11: m_out = im;
            15: npc = im;
            14: if (m_c == 0) npc = im;
            default: ;
        endcase
        m_c  = nc;
        m_pc = npc;
    endtask

    // One pin_clock rise: advance the model if this rise is a step, then queue the expected state.
    task automatic tick();
        exp_t e;
        @(posedge pin_clock);
        if (!pin_reset) begin
            rises++;
            if (rises % 4 == 2) model_step();
        end
        e.led  = 4'(m_out);
        e.slow = (rises % 4 >= 2) ? 1'b1 : 1'b0;
        e.pc   = 4'(m_pc);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_led"}, int'(pin_led), 0);
        check({tag, "_pc"}, int'(dut.pc), 0);
        check({tag, "_a"}, int'(dut.a), 0);
        check({tag, "_b"}, int'(dut.b), 0);
        check({tag, "_c"}, int'(dut.c), 0);
        check({tag, "_slow"}, int'(dut.slow_clock), 0);
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase, checked before any clock edge.
    task automatic reset_pulse(input string tag);
        @(negedge pin_clock);
        #2 pin_reset = 1'b1;
        #1 check_reset_state(tag);
        model_reset();
        tick();
        @(negedge pin_clock);
        pin_reset = 1'b0;
    endtask

    always @(negedge pin_clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pin_led !== e.led) begin
                errors++;
                $display("FAIL led: got %0h expected %0h at %0t", pin_led, e.led, $time);
            end
            checks++;
            if (dut.slow_clock !== e.slow) begin
                errors++;
                $display("FAIL slow_clock: got %0b expected %0b at %0t", dut.slow_clock, e.slow, $time);
            end
            checks++;
            if (dut.pc !== e.pc) begin
                errors++;
                $display("FAIL pc: got %0h expected %0h at %0t", dut.pc, e.pc, $time);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) m_rom[i] = 8'h00;
        m_rom[0] = 8'h20; m_rom[1] = 8'h40; m_rom[2] = 8'h90;
        m_rom[3] = 8'h51; m_rom[4] = 8'hE2; m_rom[5] = 8'hF0;
        model_reset();

        #1 pin_reset = 1'b1;
        #2 check_reset_state("por");
        tick();
        @(negedge pin_clock);
        pin_reset = 1'b0;

        // Count up from 6, wrap through JMP 0 and reload from the switches.
        repeat (150) tick();

        // All-ones input: ADD overflows every pass so LED stays at 15.
        @(negedge pin_clock);
        pin_switch = 4'hF;
        repeat (60) tick();

        for (int r = 0; r < 6; r++) begin
            @(negedge pin_clock);
            pin_switch = 4'($urandom_range(0, 15));
            repeat ($urandom_range(10, 60)) tick();
        end

        // Restart from 6, then reset while the LED shows 9.
        @(negedge pin_clock);
        pin_switch = 4'd6;
        reset_pulse("rst_restart");
        n = 0;
        while (m_out != 9 && n < 200) begin
            tick();
            n++;
        end
        check("reach_led9", (n < 200) ? 1 : 0, 1);
        reset_pulse("rst_mid");
        repeat (60) tick();

        @(negedge pin_clock);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
